// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder and its storage array.
package sram_pkg;

    localparam int WORD_W       = 32;
    localparam int LANES        = 4;
    localparam int DEF_ADDR_W   = 14;
    localparam int DEF_READ_LAT = 1;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

endpackage

// File: rtl/sram_responder_if.sv
// CPU-side SRAM bus: address/strobes/data from the CPU, read data and status back.
interface sram_responder_if #(
    parameter int ADDR_W = sram_pkg::DEF_ADDR_W
);
    import sram_pkg::*;

    logic              OE;
    logic [LANES-1:0]  WEB;
    logic [ADDR_W-1:0] A;
    logic [WORD_W-1:0] DI;
    logic [WORD_W-1:0] DO;
    logic              DO_valid;
    logic              ready;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;

    modport master (
        output OE, WEB, A, DI,
        input  DO, DO_valid, ready, rd_cnt, wr_cnt
    );

    modport slave (
        input  OE, WEB, A, DI,
        output DO, DO_valid, ready, rd_cnt, wr_cnt
    );

endinterface

// File: rtl/sram_byte_array.sv
// Word storage built from independent 8-bit lanes, each with its own write
// enable and a registered synchronous read port.
module sram_byte_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANES-1:0]  we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
            end

            // Output register only updates on a read so the last value is held.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (re) begin
                    rdata_reg <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/sram_responder.sv
// IMEM/DMEM responder: optional zero-fill after reset, byte-lane writes and a
// read path of READ_LAT cycles, with access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LAT     = DEF_READ_LAT,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    sram_responder_if.slave  bus
);

    generate
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
            $error("sram_responder: READ_LAT must be in 1..4");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [LANES-1:0]  NO_WRITE  = '1;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_addr_reg;
    logic                ready_reg;
    logic [31:0]         rd_cnt_reg;
    logic [31:0]         wr_cnt_reg;
    logic [READ_LAT-1:0] valid_pipe_reg;

    logic              clearing;
    logic              active;
    logic              wr_issue;
    logic              rd_issue;
    logic [LANES-1:0]  arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] stage_data [READ_LAT];

    assign clearing = (state_reg == S_CLEAR) && !rst;
    assign active   = (state_reg == S_READY) && !rst;
    assign wr_issue = active && (bus.WEB != NO_WRITE);
    assign rd_issue = active && bus.OE && (bus.WEB == NO_WRITE);

    // The clear sequence owns the array port; bus accesses are dropped meanwhile.
    always_comb begin
        arr_we    = '0;
        arr_addr  = bus.A;
        arr_wdata = bus.DI;
        if (clearing) begin
            arr_we    = '1;
            arr_addr  = clr_addr_reg;
            arr_wdata = '0;
        end else if (active) begin
            arr_we = ~bus.WEB;
        end
    end

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (rd_issue),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR_ON_RST ? S_CLEAR : S_READY;
            ready_reg    <= !CLEAR_ON_RST;
            clr_addr_reg <= '0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
                    if (clr_addr_reg == LAST_ADDR) begin
                        state_reg <= S_READY;
                        ready_reg <= 1'b1;
                    end
                end
                S_READY: begin
                    if (wr_issue) begin
                        wr_cnt_reg <= wr_cnt_reg + 32'd1;
                    end
                    if (rd_issue) begin
                        rd_cnt_reg <= rd_cnt_reg + 32'd1;
                    end
                end
                default: state_reg <= S_READY;
            endcase
        end
    end

    // Stage 0 is the array output register itself; later stages only advance
    // when their predecessor holds a live read, so DO holds across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg[0] <= rd_issue;
            for (int k = 1; k < READ_LAT; k++) begin
                valid_pipe_reg[k] <= valid_pipe_reg[k-1];
            end
        end
    end

    assign stage_data[0] = arr_rdata;

    genvar gi;
    generate
        for (gi = 1; gi < READ_LAT; gi++) begin : g_stage
            logic [WORD_W-1:0] data_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (valid_pipe_reg[gi-1]) begin
                    data_reg <= stage_data[gi-1];
                end
            end

            assign stage_data[gi] = data_reg;
        end
    endgenerate

    assign bus.DO       = stage_data[READ_LAT-1];
    assign bus.DO_valid = valid_pipe_reg[READ_LAT-1];
    assign bus.ready    = ready_reg;
    assign bus.rd_cnt   = rd_cnt_reg;
    assign bus.wr_cnt   = wr_cnt_reg;

    a_web_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(bus.WEB));

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the CPU's IMEM/DMEM SRAM interface: address, output enable, per-byte active-low write enable, write data and read data.
- Holds a word array of 2**ADDR_W x 32 with byte-lane writes and a registered read path of configurable latency.
- Optional post-reset zero-fill sequence.
- One instance serves as IMEM, one as DMEM; read/write counters support bench observability.

Parameters:
- ADDR_W, 14, word address width; depth = 2**ADDR_W.
- READ_LAT, 1, read latency in cycles; legal range 1..4; any other value is an elaboration error.
- CLEAR_ON_RST, 1, 1 = zero-fill the whole array after reset; 0 = ready immediately, contents untouched.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- OE  in  1  output enable; requests a read when all WEB bits are 1
- WEB  in  4  write enable per byte, active-low; bit i controls lane DI[8i+7:8i]
- A  in  ADDR_W  word address
- DI  in  32  write data
- DO  out  32  read data, registered
- DO_valid  out  1  DO carries data for a read issued READ_LAT cycles earlier
- ready  out  1  array accepts accesses; low during clear
- rd_cnt  out  32  number of accepted reads
- wr_cnt  out  32  number of accepted write cycles

Behaviour:
- Reset (rst=1 at an edge): DO=0, DO_valid=0, rd_cnt=0, wr_cnt=0, read pipeline flushed, clr_addr=0.
  - ready=0 when CLEAR_ON_RST=1, otherwise ready=1.
  - The array is not reset except through the clear sequence.
- FSM states:
  - S_CLEAR: entered on reset when CLEAR_ON_RST=1. Each cycle writes 0 to all lanes of mem[clr_addr], then increments clr_addr. When clr_addr = 2**ADDR_W-1 is written, the next state is S_READY and ready=1 from the following cycle. This takes exactly 2**ADDR_W cycles after reset deasserts.
  - S_READY: normal operation. Only rst leaves this state.
  - rst asserted in any state, including mid-clear, restarts from clr_addr=0.
- Accesses arriving during S_CLEAR are ignored: no write, no read issued, counters unchanged. Integration holds the CPU in reset until ready=1.
- Write cycle (S_READY, WEB != 4'hF):
  - Every lane i with WEB[i]=0 takes DI[8i+7:8i] into mem[A] at the edge; other lanes are unchanged.
  - wr_cnt increments by 1 per cycle, regardless of how many lanes are written.
  - Write takes priority over OE: no read is issued and DO holds its value.
- Read cycle (S_READY, WEB = 4'hF, OE=1):
  - mem[A] is sampled at the edge and appears on DO with DO_valid=1 exactly READ_LAT edges later.
  - rd_cnt increments at the issue edge.
  - Back-to-back reads are fully pipelined, one per cycle.
- Idle cycle (OE=0 and WEB=4'hF): nothing is issued. DO holds its last value; DO_valid goes 0 once the corresponding pipeline slot drains.
- Read-after-write: a read issued the cycle after a write to the same address returns the new data. There is no stale-data hazard, since the write commits at the edge before the read samples.
- rd_cnt and wr_cnt wrap modulo 2**32.
- Address is taken modulo depth (all A bits are used, no out-of-range case).
- X or Z on WEB is treated as no-write; assertion-checked in simulation.

Decomposition:
- Package sram_pkg:
  - state enum (S_CLEAR, S_READY)
  - WORD_W=32 and LANES=4 constants
  - default ADDR_W and READ_LAT localparams, shared by both instances and the bench
- One sub-module, sram_byte_array: the storage, four 8-bit lanes, with independent lane write enables and a synchronous read port.
- The FSM, clear counter, latency pipeline and counters stay in sram_responder.

Test Plan:
- Clear sequence: ADDR_W=4, CLEAR_ON_RST=1, rst high 2 cycles then low -> ready=0 for exactly 16 cycles then 1; reads of all 16 addresses return 32'h0.
- Byte lanes: write 32'hDEADBEEF to A=3 with WEB=4'h0, then 32'h11223344 with WEB=4'b1010 -> read A=3 returns 32'hDE22BE44; wr_cnt=2.
- Latency: READ_LAT=3, reads at A=1,2,3 on consecutive cycles -> DO_valid high on cycles 3,4,5 after the first issue with the matching data; rd_cnt=3.
- Priority: OE=1 with WEB=4'hE at A=5, DI=32'hAA -> lane 0 of mem[5]=8'hAA, no DO_valid pulse, rd_cnt unchanged, DO unchanged.
- Reset mid-clear: assert rst at clr_addr=7 -> clear restarts at 0, ready rises exactly 16 cycles after release, counters read 0.
- Access during clear: a write issued while ready=0 -> memory word still 0 after clear, wr_cnt=0.
